// File: rtl/order_encoder.sv
// Order-frame encoder: serialises header, address, 16-bit length and optional
// write payload byte-by-byte into an 8-bit FIFO, honouring FIFO full back-pressure.
module order_encoder #(
  parameter logic [7:0] HDR_WRITE = 8'h01,
  parameter logic [7:0] HDR_READ  = 8'h02
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_address,
  input  logic [15:0] req_length,
  input  logic        pl_valid,
  input  logic [7:0]  pl_data,
  output logic        pl_ready,
  input  logic        abort,
  output logic [7:0]  wo_data,
  output logic        wo_wr,
  input  logic        wo_full,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frames_sent
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StHdr     = 3'd1;
  localparam logic [2:0] StAddr    = 3'd2;
  localparam logic [2:0] StLenHi   = 3'd3;
  localparam logic [2:0] StLenLo   = 3'd4;
  localparam logic [2:0] StPayload = 3'd5;

  logic [2:0]  r_state, w_state_d;
  logic        r_write, w_write_d;
  logic [7:0]  r_address, w_address_d;
  logic [15:0] r_length, w_length_d;
  logic [15:0] r_remaining, w_remaining_d;
  logic        r_frame_done;
  logic [15:0] r_frames_sent;
  logic        w_last;
  logic        w_emit_ok;

  // A write is only issued when the FIFO has room and the frame is not being aborted.
  assign w_emit_ok = !wo_full && !abort;

  always_comb begin
    wo_wr    = 1'b0;
    wo_data  = 8'h00;
    pl_ready = 1'b0;
    case (r_state)
      StHdr: begin
        wo_wr   = w_emit_ok;
        wo_data = r_write ? HDR_WRITE : HDR_READ;
      end
      StAddr: begin
        wo_wr   = w_emit_ok;
        wo_data = r_address;
      end
      StLenHi: begin
        wo_wr   = w_emit_ok;
        wo_data = r_length[15:8];
      end
      StLenLo: begin
        wo_wr   = w_emit_ok;
        wo_data = r_length[7:0];
      end
      StPayload: begin
        pl_ready = w_emit_ok;
        wo_wr    = pl_valid && w_emit_ok;
        wo_data  = pl_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_d     = r_state;
    w_write_d     = r_write;
    w_address_d   = r_address;
    w_length_d    = r_length;
    w_remaining_d = r_remaining;
    w_last        = 1'b0;
    case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_write_d     = req_write;
          w_address_d   = req_address;
          w_length_d    = req_length;
          w_remaining_d = req_length;
          w_state_d     = StHdr;
        end
      end
      StHdr:   if (wo_wr) w_state_d = StAddr;
      StAddr:  if (wo_wr) w_state_d = StLenHi;
      StLenHi: if (wo_wr) w_state_d = StLenLo;
      StLenLo: begin
        if (wo_wr) begin
          if (r_write && (r_length != 16'd0)) begin
            w_state_d = StPayload;
          end else begin
            w_state_d = StIdle;
            w_last    = 1'b1;
          end
        end
      end
      StPayload: begin
        if (wo_wr) begin
          w_remaining_d = r_remaining - 16'd1;
          if (r_remaining == 16'd1) begin
            w_state_d = StIdle;
            w_last    = 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Abort drops the frame; wo_wr is already suppressed so w_last stays 0.
    if ((r_state != StIdle) && abort) begin
      w_state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state       <= StIdle;
      r_write       <= 1'b0;
      r_address     <= 8'h00;
      r_length      <= 16'h0000;
      r_remaining   <= 16'h0000;
      r_frame_done  <= 1'b0;
      r_frames_sent <= 16'h0000;
    end else begin
      r_state       <= w_state_d;
      r_write       <= w_write_d;
      r_address     <= w_address_d;
      r_length      <= w_length_d;
      r_remaining   <= w_remaining_d;
      r_frame_done  <= w_last;
      if (w_last) r_frames_sent <= r_frames_sent + 16'd1;
    end
  end

  assign req_ready   = (r_state == StIdle);
  assign busy        = (r_state != StIdle);
  assign frame_done  = r_frame_done;
  assign frames_sent = r_frames_sent;

endmodule

// File: tb/tb_order_encoder.sv
// Bench for order_encoder: random and directed frames checked against a byte-list model.
module tb_order_encoder;

  logic        clk = 1'b0;
  logic        res_n;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_address;
  logic [15:0] req_length;
  logic        pl_valid, pl_ready;
  logic [7:0]  pl_data;
  logic        abort;
  logic [7:0]  wo_data;
  logic        wo_wr, wo_full;
  logic        busy, frame_done;
  logic [15:0] frames_sent;

  order_encoder #(.HDR_WRITE(8'h01), .HDR_READ(8'h02)) dut (
    .clk(clk), .res_n(res_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_length(req_length),
    .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready),
    .abort(abort), .wo_data(wo_data), .wo_wr(wo_wr), .wo_full(wo_full),
    .busy(busy), .frame_done(frame_done), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  pay[$];
  int          pl_idx;
  int          done_cnt;
  int          viol;
  int          pl_rdy_cnt;
  logic        rdy_at_done;
  logic [15:0] exp_sent;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Sample mid-cycle, then return just after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    if (wo_wr) got.push_back(wo_data);
    if (wo_wr && wo_full) viol++;
    if (pl_ready) pl_rdy_cnt++;
    if (frame_done) begin
      done_cnt++;
      rdy_at_done = req_ready;
    end
    if (pl_valid && pl_ready) pl_idx++;
    @(posedge clk);
    #1;
  endtask

  task automatic make_payload(input int len);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
  endtask

  // Reference: a frame is simply its header bytes followed by the payload of a write.
  task automatic build_exp(input logic wr, input logic [7:0] addr, input logic [15:0] len);
    exp_q.delete();
    exp_q.push_back(wr ? 8'h01 : 8'h02);
    exp_q.push_back(addr);
    exp_q.push_back(len[15:8]);
    exp_q.push_back(len[7:0]);
    if (wr) for (int i = 0; i < int'(len); i++) exp_q.push_back(pay[i]);
  endtask

  task automatic drive_pl(input int gap_pct);
    pl_valid = ($urandom_range(0, 99) >= gap_pct);
    pl_data  = (pl_idx < pay.size()) ? pay[pl_idx] : 8'($urandom);
  endtask

  task automatic accept(input logic wr, input logic [7:0] addr, input logic [15:0] len);
    got.delete();
    done_cnt = 0; viol = 0; pl_idx = 0; pl_rdy_cnt = 0; rdy_at_done = 1'b0;
    build_exp(wr, addr, len);
    req_valid = 1'b1; req_write = wr; req_address = addr; req_length = len;
    wo_full = 1'b0;
    drive_pl(100);
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic run_frame(input logic wr, input logic [7:0] addr, input logic [15:0] len,
                           input int full_pct, input int gap_pct, input string tag);
    int n;
    n = 0;
    accept(wr, addr, len);
    while (done_cnt == 0 && n < 300) begin
      wo_full = ($urandom_range(0, 99) < full_pct);
      drive_pl(gap_pct);
      cycle();
      n++;
    end
    wo_full = 1'b0; pl_valid = 1'b0;
    if (done_cnt != 0) exp_sent = exp_sent + 16'd1;
    chk({tag, "_done_seen"}, done_cnt, 1);
    chk({tag, "_nbytes"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
    chk({tag, "_wr_while_full"}, viol, 0);
    chk({tag, "_frames_sent"}, frames_sent, exp_sent);
    chk({tag, "_ready_after_last"}, rdy_at_done, 1);
    if (full_pct == 0 && gap_pct == 0) chk({tag, "_cycles"}, n, exp_q.size() + 1);
    if (!wr) chk({tag, "_pl_ready_read"}, pl_rdy_cnt, 0);
    cycle();
    chk({tag, "_done_one_pulse"}, done_cnt, 1);
    chk({tag, "_no_extra"}, got.size(), exp_q.size());
  endtask

  initial begin
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] len;
    int          n;
    res_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_address = 8'h00;
    req_length = 16'h0000; pl_valid = 1'b0; pl_data = 8'h00; abort = 1'b0; wo_full = 1'b0;
    exp_sent = 16'h0000;
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_wo_wr", wo_wr, 0);
    chk("rst_wo_data", wo_data, 0);
    chk("rst_pl_ready", pl_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frames_sent", frames_sent, 0);
    @(posedge clk); #1 res_n = 1'b1;

    pay.delete(); pay.push_back(8'hA1); pay.push_back(8'hB2); pay.push_back(8'hC3);
    run_frame(1'b1, 8'h23, 16'd3, 0, 0, "wr3");

    make_payload(0);
    run_frame(1'b0, 8'h40, 16'h0100, 0, 0, "rd");

    make_payload(2);
    accept(1'b1, 8'h77, 16'd2);
    build_exp(1'b1, 8'h77, 16'd2);
    cycle();
    // Stall starting on the ADDR cycle for 5 cycles, with payload gaps afterwards.
    n = 0;
    wo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin drive_pl(50); cycle(); end
    wo_full = 1'b0;
    while (done_cnt == 0 && n < 100) begin drive_pl(50); cycle(); n++; end
    pl_valid = 1'b0;
    exp_sent = exp_sent + 16'd1;
    chk("stall_nbytes", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("stall_byte%0d", i), got[i], exp_q[i]);
    chk("stall_wr_while_full", viol, 0);
    chk("stall_frames_sent", frames_sent, exp_sent);

    for (int f = 0; f < 12; f++) begin
      wr = 1'($urandom);
      addr = 8'($urandom);
      len = 16'($urandom_range(0, 6));
      make_payload(int'(len));
      run_frame(wr, addr, len, 30, 30, "rnd");
    end

    make_payload(4);
    accept(1'b1, 8'h5A, 16'd4);
    n = 0;
    while (got.size() < 5 && n < 50) begin drive_pl(0); cycle(); n++; end
    abort = 1'b1; drive_pl(0);
    cycle();
    abort = 1'b0; pl_valid = 1'b0;
    chk("abort_nbytes", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk($sformatf("abort_byte%0d", i), got[i], exp_q[i]);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_frames_sent", frames_sent, exp_sent);
    chk("abort_ready_next", req_ready, 1);
    make_payload(1);
    run_frame(1'b1, 8'h11, 16'd1, 0, 0, "post_abort");

    make_payload(0);
    accept(1'b1, 8'h99, 16'hFFFF);
    n = 0;
    while (got.size() < 6 && n < 50) begin drive_pl(0); cycle(); n++; end
    chk("maxlen_hi", got.size() > 2 ? got[2] : 8'h00, 8'hFF);
    chk("maxlen_lo", got.size() > 3 ? got[3] : 8'h00, 8'hFF);
    chk("maxlen_busy", busy, 1);
    abort = 1'b1; cycle(); abort = 1'b0; pl_valid = 1'b0;

    accept(1'b0, 8'h55, 16'd7);
    n = 0;
    while (got.size() < 2 && n < 50) begin cycle(); n++; end
    res_n = 1'b0;
    #1;
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_wo_wr", wo_wr, 0);
    chk("midrst_wo_data", wo_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_frames_sent", frames_sent, 0);
    chk("midrst_frame_done", frame_done, 0);
    @(posedge clk); #1 res_n = 1'b1;
    exp_sent = 16'h0000;
    make_payload(2);
    run_frame(1'b1, 8'h66, 16'd2, 0, 0, "after_rst");

    force dut.r_frames_sent = 16'hFFFE;
    #1;
    release dut.r_frames_sent;
    exp_sent = 16'hFFFE;
    make_payload(0);
    run_frame(1'b1, 8'h01, 16'd0, 0, 0, "b2b_a");
    run_frame(1'b1, 8'h02, 16'd0, 0, 0, "b2b_b");
    chk("wrap_zero", frames_sent, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
